guess_entry: RTL and testbench

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/guess_entry_pkg.sv | 22 ++
 rtl/guess_entry_dup_check.sv | 15 +
 rtl/guess_entry.sv | 142 ++++++++++++++
 tb/tb_guess_entry.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_entry_pkg.sv
// Shared definitions for the guess entry block: digit geometry, blank code
// and the entry FSM state encoding.
package guess_entry_pkg;

    localparam int DIGIT_W        = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int GUESS_W        = DIGIT_W * DEF_NUM_DIGITS;
    localparam int CNT_W          = 3;
    localparam logic [DIGIT_W-1:0] DEF_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OFFER   = 2'd2
    } state_t;

    // A switch value is a legal BCD digit only in the range 0..9.
    function automatic logic is_digit(input logic [DIGIT_W-1:0] value);
        return value <= 4'd9;
    endfunction

endpackage

// File: rtl/guess_entry_dup_check.sv
// Combinational repeat detector: flags any pair of equal nibbles among four.
module dup_check
    import guess_entry_pkg::*;
(
    input  logic [DIGIT_W-1:0] d0,
    input  logic [DIGIT_W-1:0] d1,
    input  logic [DIGIT_W-1:0] d2,
    input  logic [DIGIT_W-1:0] d3,
    output logic               dup
);

    assign dup = (d0 == d1) || (d0 == d2) || (d0 == d3) ||
                 (d1 == d2) || (d1 == d3) || (d2 == d3);

endmodule

// File: rtl/guess_entry.sv
// Collects four BCD digits from debounced buttons, rejects illegal or
// repeating guesses, and offers a legal guess over a valid/ready handshake.
//
// Handshake: guess_valid rises only with a complete, repeat-free guess and then
// holds, with guess stable, until the edge at which guess_ready is also 1;
// that edge is the transfer. guess_ready has no effect while guess_valid is 0.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter int                 NUM_DIGITS = DEF_NUM_DIGITS,
    parameter logic [DIGIT_W-1:0] BLANK      = DEF_BLANK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] in,
    input  logic               guess_ready,
    output logic               guess_valid,
    output logic [GUESS_W-1:0] guess,
    output logic [GUESS_W-1:0] disp,
    output logic [CNT_W-1:0]   digit_count,
    output logic               err,
    output logic [3:0]         attempts,
    output state_t             fsm_state
);

    localparam logic [GUESS_W-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(NUM_DIGITS - 1);

    state_t             state_q, state_d;
    logic [GUESS_W-1:0] digits_q, digits_d;
    logic [GUESS_W-1:0] disp_q, disp_d;
    logic [GUESS_W-1:0] guess_q, guess_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [3:0]         attempts_q, attempts_d;
    logic               repeat_found;

    // digits_q[15:12] holds the first entered digit once four are in.
    dup_check u_dup_check (
        .d0  (digits_q[15:12]),
        .d1  (digits_q[11:8]),
        .d2  (digits_q[7:4]),
        .d3  (digits_q[3:0]),
        .dup (repeat_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            digits_q   <= '0;
            disp_q     <= ALL_BLANK;
            guess_q    <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            disp_q     <= disp_d;
            guess_q    <= guess_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            attempts_q <= attempts_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        disp_d     = disp_q;
        guess_d    = guess_q;
        count_d    = count_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        attempts_d = attempts_q;

        case (state_q)
            ST_COLLECT: begin
                if (clear) begin
                    count_d = '0;
                    disp_d  = ALL_BLANK;
                end else if (enter) begin
                    if (is_digit(in)) begin
                        digits_d = {digits_q[GUESS_W-DIGIT_W-1:0], in};
                        count_d  = count_q + 1'b1;
                        // The display fills from the top nibble downward.
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                disp_d[GUESS_W-1-DIGIT_W*i -: DIGIT_W] = in;
                            end
                        end
                        if (count_q == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (repeat_found) begin
                    err_d   = 1'b1;
                    count_d = '0;
                    disp_d  = ALL_BLANK;
                    state_d = ST_COLLECT;
                end else begin
                    guess_d = digits_q;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (guess_ready) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    disp_d  = ALL_BLANK;
                    state_d = ST_COLLECT;
                    if (attempts_q != 4'hF) begin
                        attempts_d = attempts_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign guess_valid = valid_q;
    assign guess       = guess_q;
    assign disp        = disp_q;
    assign digit_count = count_q;
    assign err         = err_q;
    assign attempts    = attempts_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed scenarios plus random key presses, with a
// list-based model of the entry rules and a scoreboard on guesses and errors.
module tb_guess_entry;
    import guess_entry_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  in = 4'd0;
    logic        guess_ready = 1'b0;
    logic        guess_valid;
    logic [15:0] guess;
    logic [15:0] disp;
    logic [2:0]  digit_count;
    logic        err;
    logic [3:0]  attempts;
    state_t      fsm_state;

    guess_entry dut (
        .clk         (clk),
        .rst         (rst),
        .enter       (enter),
        .clear       (clear),
        .in          (in),
        .guess_ready (guess_ready),
        .guess_valid (guess_valid),
        .guess       (guess),
        .disp        (disp),
        .digit_count (digit_count),
        .err         (err),
        .attempts    (attempts),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    int          entered[$];
    int          err_pend = 0;
    int          att_model = 0;
    int          valid_run = 0;
    int          last_run = 0;
    bit          prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the entered digits as a plain list.
    function automatic logic [15:0] model_disp();
        logic [15:0] d = 16'hFFFF;
        foreach (entered[i]) d[15-4*i -: 4] = 4'(entered[i]);
        return d;
    endfunction

    function automatic logic [15:0] model_guess();
        logic [15:0] g = 16'h0000;
        foreach (entered[i]) g = {g[11:0], 4'(entered[i])};
        return g;
    endfunction

    function automatic bit model_unique();
        foreach (entered[i])
            for (int j = i + 1; j < entered.size(); j++)
                if (entered[i] == entered[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_collect(input int low_cycles, input bit rand_ready, input bit noise);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (i < low_cycles) guess_ready = 1'b0;
            else guess_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                enter = 1'($urandom_range(0, 1));
                clear = 1'($urandom_range(0, 1));
                in    = 4'($urandom_range(0, 15));
            end
            step();
            if (fsm_state == ST_COLLECT && !guess_valid) done = 1'b1;
        end
        enter = 1'b0;
        clear = 1'b0;
        guess_ready = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_collect timeout state=%0d expected=%0d", fsm_state, ST_COLLECT);
        end
    endtask

    task automatic do_enter(input logic [3:0] d, input bit hold_offer, input int low_cycles,
                            input bit rand_ready, input bit noise);
        bit full = 1'b0;
        if (d > 4'd9) begin
            err_pend++;
        end else begin
            entered.push_back(int'(d));
            if (entered.size() == 4) begin
                full = 1'b1;
                if (model_unique()) exp_q.push_back(model_guess());
                else err_pend++;
            end
        end
        enter = 1'b1;
        in = d;
        step();
        enter = 1'b0;
        if (full) begin
            entered.delete();
            if (!hold_offer) begin
                wait_collect(low_cycles, rand_ready, noise);
                check("count_after_guess", 32'(digit_count), 32'd0);
                check("disp_after_guess", 32'(disp), 32'hFFFF);
                step();
            end
        end else begin
            check("digit_count", 32'(digit_count), 32'(entered.size()));
            check("disp", 32'(disp), 32'(model_disp()));
            if (d > 4'd9) step();
        end
    endtask

    task automatic do_clear(input bit with_enter);
        entered.delete();
        clear = 1'b1;
        enter = with_enter;
        in = 4'd5;
        step();
        clear = 1'b0;
        enter = 1'b0;
        check("count_after_clear", 32'(digit_count), 32'd0);
        check("disp_after_clear", 32'(disp), 32'hFFFF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        guess_ready = 1'b0;
        enter = 1'b0;
        clear = 1'b0;
        step();
        exp_q.delete();
        entered.delete();
        err_pend = 0;
        att_model = 0;
        check("rst_valid", 32'(guess_valid), 32'd0);
        check("rst_guess", 32'(guess), 32'h0);
        check("rst_disp", 32'(disp), 32'hFFFF);
        check("rst_count", 32'(digit_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_attempts", 32'(attempts), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_COLLECT));
        rst = 1'b0;
    endtask

    task automatic legal_guess(input bit rand_ready);
        int pick[$];
        while (pick.size() < 4) begin
            int v = $urandom_range(0, 9);
            bit seen = 1'b0;
            foreach (pick[k]) if (pick[k] == v) seen = 1'b1;
            if (!seen) pick.push_back(v);
        end
        foreach (pick[k]) do_enter(4'(pick[k]), 1'b0, 0, rand_ready, 1'b0);
    endtask

    // Monitor: compares every offered guess and every err pulse against the model.
    always @(negedge clk) begin
        if (rst) begin
            prev_err = 1'b0;
            valid_run = 0;
        end else begin
            if (guess_valid) begin
                valid_run++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid guess=%0h expected no guess", guess);
                end else begin
                    check("guess", 32'(guess), 32'(exp_q[0]));
                    if (guess_ready) begin
                        check("attempts_at_transfer", 32'(attempts), 32'(att_model));
                        void'(exp_q.pop_front());
                        if (att_model < 15) att_model++;
                        last_run = valid_run;
                        valid_run = 0;
                    end
                end
            end else begin
                valid_run = 0;
            end
            if (err) begin
                total++;
                if (err_pend == 0) begin
                    bad++;
                    $display("FAIL unexpected_err err=1 expected 0");
                end else begin
                    err_pend--;
                end
                check("err_single_cycle", 32'(prev_err), 32'd0);
            end
            prev_err = err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset();

        // 1,2,3,4 with ready held high
        do_enter(4'd1, 0, 0, 0, 0);
        do_enter(4'd2, 0, 0, 0, 0);
        do_enter(4'd3, 0, 0, 0, 0);
        do_enter(4'd4, 0, 0, 0, 0);
        check("valid_cycles_1234", 32'(last_run), 32'd1);
        check("attempts_1234", 32'(attempts), 32'd1);

        // repeated digit
        do_enter(4'd5, 0, 0, 0, 0);
        do_enter(4'd5, 0, 0, 0, 0);
        do_enter(4'd6, 0, 0, 0, 0);
        do_enter(4'd7, 0, 0, 0, 0);
        check("err_drained_dup", 32'(err_pend), 32'd0);
        check("attempts_after_dup", 32'(attempts), 32'd1);

        // illegal switch value after one digit
        do_enter(4'd1, 0, 0, 0, 0);
        do_enter(4'hB, 0, 0, 0, 0);
        check("err_drained_illegal", 32'(err_pend), 32'd0);
        check("disp_1fff", 32'(disp), 32'h1FFF);
        do_clear(1'b0);

        // held offer with button noise
        do_enter(4'd9, 0, 0, 0, 0);
        do_enter(4'd8, 0, 0, 0, 0);
        do_enter(4'd7, 0, 0, 0, 0);
        do_enter(4'd6, 0, 11, 0, 1);
        check("hold_run_long", 32'(last_run >= 10), 32'd1);
        check("attempts_9876", 32'(attempts), 32'd2);

        // clear beats enter
        do_enter(4'd3, 0, 0, 0, 0);
        do_enter(4'd4, 0, 0, 0, 0);
        do_clear(1'b1);

        // reset while a guess is offered
        do_enter(4'd1, 0, 0, 0, 0);
        do_enter(4'd2, 0, 0, 0, 0);
        do_enter(4'd3, 0, 0, 0, 0);
        do_enter(4'd4, 1, 0, 0, 0);
        step();
        step();
        check("valid_before_reset", 32'(guess_valid), 32'd1);
        do_reset();

        // saturation
        for (int n = 0; n < 16; n++) legal_guess(1'b1);
        check("attempts_saturated", 32'(attempts), 32'd15);

        // random key presses
        do_reset();
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 9) == 0) do_clear(1'($urandom_range(0, 1)));
            else do_enter(4'($urandom_range(0, 11)), 0, $urandom_range(0, 4), 1, 1'($urandom_range(0, 1)));
        end
        check("attempts_random", 32'(attempts), 32'(att_model));

        step();
        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("err_pend_empty", 32'(err_pend), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
